// File: rtl/button_debounce_bank.sv
// Debounced button bank: 2-flop sync, shared sample tick, press/release pulses.
// Define AUTO_REPEAT_EN to add per-channel auto-repeat of the press pulse.
module button_debounce_bank #(
  parameter int CHANNELS      = 4,
  parameter int TICK_DIV      = 100000,
  parameter int STABLE_TICKS  = 3,
  parameter int REPEAT_DELAY  = 250,
  parameter int REPEAT_PERIOD = 50
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic [CHANNELS-1:0] D,
  output logic [CHANNELS-1:0] LEVEL,
  output logic [CHANNELS-1:0] SP,
  output logic [CHANNELS-1:0] RP
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(STABLE_TICKS + 1);
  localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SLAST = SW'(STABLE_TICKS);

  // Elaboration-only guard on the configuration space.
  if (CHANNELS < 1 || CHANNELS > 32 || TICK_DIV < 2 ||
      STABLE_TICKS < 1 || REPEAT_DELAY < 1 ||
      REPEAT_PERIOD < 1) begin : g_bad_params
  end

  logic [CHANNELS-1:0] sy1_q;
  logic [CHANNELS-1:0] sy2_q;
  logic [TW-1:0]       tc_q;
  logic [TW-1:0]       tc_d;
  logic                tick;
  logic [CHANNELS-1:0] lvl_q;
  logic [CHANNELS-1:0] lvl_d;
  logic [CHANNELS-1:0] sp_q;
  logic [CHANNELS-1:0] sp_d;
  logic [CHANNELS-1:0] rp_q;
  logic [CHANNELS-1:0] rp_d;
  logic [CHANNELS-1:0] press;
  logic [CHANNELS-1:0] rel;
  logic [CHANNELS-1:0] rep_fire;
  logic [SW-1:0]       st_q [CHANNELS];
  logic [SW-1:0]       st_d [CHANNELS];

  always_comb begin
    tick = (tc_q == TLAST);
    tc_d = tick ? '0 : tc_q + TW'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      sy1_q <= '0;
      sy2_q <= '0;
      tc_q  <= '0;
    end else begin
      sy1_q <= D;
      sy2_q <= sy1_q;
      tc_q  <= tc_d;
    end
  end

  always_comb begin
    lvl_d = lvl_q;
    press = '0;
    rel   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      st_d[i] = st_q[i];
      if (tick) begin
        if (sy2_q[i] == lvl_q[i]) begin
          st_d[i] = '0;
        end else if (st_q[i] + SW'(1) == SLAST) begin
          st_d[i]  = '0;
          lvl_d[i] = ~lvl_q[i];
          press[i] = ~lvl_q[i];
          rel[i]   = lvl_q[i];
        end else begin
          st_d[i] = st_q[i] + SW'(1);
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RDLY = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RPER = RW'(REPEAT_PERIOD);

  logic [RW-1:0]       rc_q [CHANNELS];
  logic [RW-1:0]       rc_d [CHANNELS];
  logic [CHANNELS-1:0] rph_q;
  logic [CHANNELS-1:0] rph_d;

  // rph marks that the initial delay has elapsed; later gaps use RPER.
  always_comb begin
    rph_d    = rph_q;
    rep_fire = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      rc_d[i] = rc_q[i];
      if (!lvl_d[i] || press[i]) begin
        rc_d[i]  = '0;
        rph_d[i] = 1'b0;
      end else if (tick) begin
        if (rc_q[i] + RW'(1) == (rph_q[i] ? RPER : RDLY)) begin
          rep_fire[i] = 1'b1;
          rc_d[i]     = '0;
          rph_d[i]    = 1'b1;
        end else begin
          rc_d[i] = rc_q[i] + RW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      rph_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        rc_q[i] <= '0;
      end
    end else begin
      rph_q <= rph_d;
      for (int i = 0; i < CHANNELS; i++) begin
        rc_q[i] <= rc_d[i];
      end
    end
  end
`else
  assign rep_fire = '0;
`endif

  always_comb begin
    sp_d = press | rep_fire;
    rp_d = rel;
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      lvl_q <= '0;
      sp_q  <= '0;
      rp_q  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        st_q[i] <= '0;
      end
    end else begin
      lvl_q <= lvl_d;
      sp_q  <= sp_d;
      rp_q  <= rp_d;
      for (int i = 0; i < CHANNELS; i++) begin
        st_q[i] <= st_d[i];
      end
    end
  end

  assign LEVEL = lvl_q;
  assign SP    = sp_q;
  assign RP    = rp_q;

endmodule

// File: tb/tb_button_debounce_bank.sv
// Bench for button_debounce_bank: per-cycle model compare plus directed checks.
// Build with AUTO_REPEAT_EN defined to exercise the auto-repeat path.
module tb_button_debounce_bank;

  localparam int CH   = 4;
  localparam int TD   = 4;
  localparam int ST   = 3;
  localparam int RD   = 4;
  localparam int RPER = 2;
`ifdef AUTO_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          RESETn;
  logic [CH-1:0] D;
  logic [CH-1:0] LEVEL;
  logic [CH-1:0] SP;
  logic [CH-1:0] RP;

  int n_chk = 0;
  int n_err = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  button_debounce_bank #(
    .CHANNELS     (CH),
    .TICK_DIV     (TD),
    .STABLE_TICKS (ST),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RPER)
  ) dut (
    .CLK   (clk),
    .RESETn(RESETn),
    .D     (D),
    .LEVEL (LEVEL),
    .SP    (SP),
    .RP    (RP)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a level flips once the last ST tick samples taken since the
  // previous flip all disagree with it; repeats counted in held ticks.
  initial begin : model
    logic [CH-1:0] s1, s2, lvl, sp, rp;
    int unsigned   cyc;
    bit            hq [CH][$];
    int            held [CH];
    bit            tk;
    bit            all_diff;
    s1 = '0; s2 = '0; lvl = '0; sp = '0; rp = '0; cyc = 0;
    for (int c = 0; c < CH; c++) held[c] = 0;
    forever begin
      @(posedge clk);
      if (RESETn !== 1'b1) begin
        s1 = '0; s2 = '0; lvl = '0; sp = '0; rp = '0; cyc = 0;
        for (int c = 0; c < CH; c++) begin
          hq[c].delete();
          held[c] = 0;
        end
        armed = 1'b1;
      end else begin
        tk = (cyc % TD) == TD - 1;
        cyc++;
        sp = '0;
        rp = '0;
        for (int c = 0; c < CH; c++) begin
          if (tk) begin
            hq[c].push_back(s2[c]);
            if (hq[c].size() > ST) void'(hq[c].pop_front());
            all_diff = (hq[c].size() == ST);
            for (int k = 0; k < hq[c].size(); k++)
              if (hq[c][k] == lvl[c]) all_diff = 1'b0;
            if (all_diff) begin
              sp[c]   = ~lvl[c];
              rp[c]   = lvl[c];
              lvl[c]  = ~lvl[c];
              hq[c].delete();
              held[c] = 0;
            end else if (REP && lvl[c]) begin
              held[c]++;
              if (held[c] == RD ||
                  (held[c] > RD && (held[c] - RD) % RPER == 0))
                sp[c] = 1'b1;
            end
          end
        end
        s2 = s1;
        s1 = D;
      end
      @(negedge clk);
      if (armed) begin
        chk("model_LEVEL", LEVEL, lvl);
        chk("model_SP", SP, sp);
        chk("model_RP", RP, rp);
      end
    end
  end

  task automatic win(input int ch, input int n, output int spn,
                     output int rpn, output int oth);
    logic [CH-1:0] m;
    m = 1 << ch;
    spn = 0; rpn = 0; oth = 0;
    repeat (n) begin
      @(negedge clk);
      spn += int'(SP[ch]);
      rpn += int'(RP[ch]);
      oth += int'(((SP | RP) & ~m) != '0);
    end
  endtask

  initial begin : stim
    int  a, b, o, ta, tb_n, cnt;
    bit  found;
    RESETn = 1'b0;
    D      = '0;
    repeat (3) @(negedge clk);
    chk("rst_LEVEL", LEVEL, 4'h0);
    chk("rst_SP", SP, 4'h0);
    chk("rst_RP", RP, 4'h0);

    RESETn = 1'b1;
    D = 4'b0001;
    win(0, 15, a, b, o);
    chk("press0_sp", a, 1);
    chk("press0_rp", b, 0);
    chk("press0_other", o, 0);
    chk("press0_level", LEVEL, 4'b0001);

    D = 4'b0000;
    win(0, 15, a, b, o);
    chk("rel0_rp", b, 1);
    chk("rel0_sp", a, 0);
    chk("rel0_level", LEVEL, 4'b0000);

    ta = 0; tb_n = 0;
    for (int i = 0; i < 16; i++) begin
      D[1] = ~D[1];
      win(1, 3, a, b, o);
      ta += a;
      tb_n += b;
    end
    chk("bounce1_sp", ta, 0);
    chk("bounce1_rp", tb_n, 0);
    D[1] = 1'b1;
    win(1, 15, a, b, o);
    chk("settle1_sp", a, 1);
    chk("settle1_rp", b, 0);
    chk("settle1_level", LEVEL, 4'b0010);

    D = 4'b0000;
    repeat (20) @(negedge clk);
    D = 4'b1111;
    found = 1'b0;
    for (int k = 0; k < 15 && !found; k++) begin
      @(negedge clk);
      if (SP != '0) found = 1'b1;
    end
    chk("all_found", found, 1);
    chk("all_sp", SP, 4'b1111);
    @(negedge clk);
    chk("all_sp_after", SP, 4'b0000);
    chk("all_level", LEVEL, 4'b1111);

    repeat (3) @(negedge clk);
    RESETn = 1'b0;
    @(negedge clk);
    chk("mid_rst_level", LEVEL, 4'h0);
    chk("mid_rst_sp", SP, 4'h0);
    chk("mid_rst_rp", RP, 4'h0);
    @(negedge clk);
    RESETn = 1'b1;
    win(2, 15, a, b, o);
    chk("post_rst_sp2", a, 1);
    chk("post_rst_rp2", b, 0);
    chk("post_rst_level2", LEVEL[2], 1);

    D = 4'b0000;
    repeat (20) @(negedge clk);
    D = 4'b0001;
    found = 1'b0;
    for (int k = 0; k < 15 && !found; k++) begin
      @(negedge clk);
      if (SP[0]) found = 1'b1;
    end
    chk("rep_found", found, 1);
    cnt = int'(SP[0]);
    repeat (40) begin
      @(negedge clk);
      cnt += int'(SP[0]);
    end
    chk("rep_count", cnt, REP ? 5 : 1);
    chk("rep_level", LEVEL, 4'b0001);

    D = 4'b0000;
    repeat (20) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
